// File: rtl/frame_pkg.sv
// Shared types and constants for the frame write scheduler.
// frame_t packs the frame MSB first as {t, x[5:2], y[2:7], z[7:2][2:9]},
// so nibble order from the top of the vector is also the readout order.
package frame_pkg;

    localparam int FRAME_W   = 221;
    localparam int HDR_BEATS = 2;
    localparam int Y_BEATS   = 6;
    localparam int Z_BEATS   = 48;

    typedef logic [2:7][3:0]      sy_t;
    typedef logic [7:2][2:9][3:0] sz_t;

    typedef struct packed {
        logic       t;
        logic [5:2] x;
        sy_t        y;
        sz_t        z;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        YSEQ = 2'd2,
        ZSEQ = 2'd3
    } state_t;

endpackage

// File: rtl/frame_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. Priority only moves on contention: the holder
// wins and hands priority to the other side; a lone requester is simply granted.
module rr_arb2
#(
    parameter bit PRIO_INIT = 1'b0
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_prio;   // 0: A holds priority, 1: B holds priority
    logic w_both;

    assign w_both = i_en && i_req_a && i_req_b;

    // Grant decode, purely combinational from requests and priority.
    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        if (i_en) begin
            if (i_req_a && i_req_b) begin
                o_gnt_a = ~r_prio;
                o_gnt_b = r_prio;
            end else begin
                o_gnt_a = i_req_a;
                o_gnt_b = i_req_b;
            end
        end
    end

    // Priority flips after every contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_INIT;
        end else if (w_both) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/frame_write_scheduler.sv
// Frame write scheduler: arbitrated y/z element writes, header writes, and a
// nibble-stream readout of the whole frame with valid/ready handshake.
// Optional build macro FRAME_PARITY_EN appends an XOR parity beat.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no readout; writes and header updates accepted
// HDR   | beats {000,t} then x; r_cnt counts down 1..0
// YSEQ  | beats y[2]..y[7]; r_cnt counts down 5..0
// ZSEQ  | beats z[7][2]..z[2][9] (+ parity beat at r_cnt==0 if enabled)
module frame_write_scheduler
    import frame_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_req,
    input  logic [2:0]         a_idx,
    input  logic [3:0]         a_data,
    output logic               a_gnt,
    input  logic               b_req,
    input  logic [2:0]         b_row,
    input  logic [3:0]         b_col,
    input  logic [3:0]         b_data,
    output logic               b_gnt,
    input  logic               hdr_we,
    input  logic               hdr_t,
    input  logic [3:0]         hdr_x,
    input  logic               start,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_data,
    output logic               out_last,
    output logic               idx_err,
    output logic [FRAME_W-1:0] frame_q
);

`ifdef FRAME_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif

    localparam logic [5:0] HDR_LOAD = 6'(HDR_BEATS - 1);
    localparam logic [5:0] Y_LOAD   = 6'(Y_BEATS - 1);
    localparam logic [5:0] Z_LOAD   = 6'(Z_BEATS - 1 + PAR_BEATS);
    // Nibble number (0 = x) of the first z beat plus Z_LOAD, so nibble = Z_TOP - r_cnt.
    localparam logic [5:0] Z_TOP    = 6'(HDR_BEATS - 1 + Y_BEATS) + Z_LOAD;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_cnt;
    logic [5:0]   w_cnt_nxt;
    frame_t       r_frame;
    logic         r_idx_err;
    logic         w_a_legal;
    logic         w_b_legal;
    logic         w_xfer;
    logic         w_tc;
    logic [5:0]   w_nib;
    logic [7:0]   w_pos;
    logic [3:0]   w_sel;

`ifdef FRAME_PARITY_EN
    // XOR of the {000,t} beat and every 4-bit nibble below it.
    function automatic logic [3:0] frame_parity(input frame_t f);
        logic [219:0] v;
        logic [3:0]   p;
        v = f[219:0];
        p = {3'b000, f.t};
        for (int i = 0; i < 55; i++) begin
            p = p ^ v[4*i +: 4];
        end
        return p;
    endfunction
`endif

    assign w_a_legal = (a_idx >= 3'd2);
    assign w_b_legal = (b_row >= 3'd2) && (b_col >= 4'd2) && (b_col <= 4'd9);

    assign busy      = (r_state != IDLE);
    assign out_valid = busy;
    assign w_xfer    = out_valid && out_ready;
    assign w_tc      = (r_cnt == 6'd0);
    assign idx_err   = r_idx_err;
    assign frame_q   = r_frame;

    rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (!busy),
        .i_req_a (a_req),
        .i_req_b (b_req),
        .o_gnt_a (a_gnt),
        .o_gnt_b (b_gnt)
    );

    // Frame storage: granted element writes, header writes, sticky index error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_idx_err <= 1'b0;
        end else begin
            if (hdr_we && !busy) begin
                r_frame.t <= hdr_t;
                r_frame.x <= hdr_x;
            end
            if (a_gnt) begin
                if (w_a_legal) r_frame.y[a_idx] <= a_data;
                else           r_idx_err <= 1'b1;
            end
            if (b_gnt) begin
                if (w_b_legal) r_frame.z[b_row][b_col] <= b_data;
                else           r_idx_err <= 1'b1;
            end
        end
    end

    // Readout state and per-segment down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: each segment advances on a transfer at terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = HDR;
                    w_cnt_nxt   = HDR_LOAD;
                end
            end
            HDR: begin
                if (w_xfer) begin
                    if (w_tc) begin
                        w_state_nxt = YSEQ;
                        w_cnt_nxt   = Y_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            YSEQ: begin
                if (w_xfer) begin
                    if (w_tc) begin
                        w_state_nxt = ZSEQ;
                        w_cnt_nxt   = Z_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            ZSEQ: begin
                if (w_xfer) begin
                    if (w_tc) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 6'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    assign w_pos = 8'd219 - {w_nib, 2'b00};
    assign w_sel = frame_q[w_pos -: 4];

    // Beat data: live nibble from the frame; stable while stalled because
    // neither state, counter nor frame can change without a transfer.
    always_comb begin
        w_nib    = 6'd0;
        out_data = 4'd0;
        out_last = 1'b0;
        case (r_state)
            HDR: begin
                out_data = w_tc ? w_sel : {3'b000, r_frame.t};
            end
            YSEQ: begin
                w_nib    = 6'(Y_BEATS) - r_cnt;
                out_data = w_sel;
            end
            ZSEQ: begin
                out_last = w_tc;
`ifdef FRAME_PARITY_EN
                if (w_tc) begin
                    out_data = frame_parity(r_frame);
                end else begin
                    w_nib    = Z_TOP - r_cnt;
                    out_data = w_sel;
                end
`else
                w_nib    = Z_TOP - r_cnt;
                out_data = w_sel;
`endif
            end
            default: begin
                out_data = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed bench for frame_write_scheduler: arbitration, index errors,
// header writes, full readout with stall, busy lockout and mid-stream reset.
module tb_frame_write_scheduler;
    import frame_pkg::*;

`ifdef FRAME_PARITY_EN
    localparam int N_BEATS = 57;
`else
    localparam int N_BEATS = 56;
`endif

    logic         clk;
    logic         rst_n;
    logic         a_req;
    logic [2:0]   a_idx;
    logic [3:0]   a_data;
    logic         a_gnt;
    logic         b_req;
    logic [2:0]   b_row;
    logic [3:0]   b_col;
    logic [3:0]   b_data;
    logic         b_gnt;
    logic         hdr_we;
    logic         hdr_t;
    logic [3:0]   hdr_x;
    logic         start;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_data;
    logic         out_last;
    logic         idx_err;
    logic [220:0] frame_q;

    int           checks;
    int           errors;
    frame_t       exp_f;
    logic [3:0]   exp_beats [0:56];

    frame_write_scheduler #(.PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_idx     (a_idx),
        .a_data    (a_data),
        .a_gnt     (a_gnt),
        .b_req     (b_req),
        .b_row     (b_row),
        .b_col     (b_col),
        .b_data    (b_data),
        .b_gnt     (b_gnt),
        .hdr_we    (hdr_we),
        .hdr_t     (hdr_t),
        .hdr_x     (hdr_x),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .idx_err   (idx_err),
        .frame_q   (frame_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [220:0] obs, input logic [220:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic [2:0] ai, input logic [3:0] ad,
                         input logic br, input logic [2:0] brow, input logic [3:0] bc,
                         input logic [3:0] bd);
        a_req = ar; a_idx = ai; a_data = ad;
        b_req = br; b_row = brow; b_col = bc; b_data = bd;
    endtask

    // Expected beat sequence built field by field from the model frame.
    task automatic build_beats(input frame_t f);
        int n;
        logic [3:0] p;
        exp_beats[0] = {3'b000, f.t};
        exp_beats[1] = f.x;
        n = 2;
        for (int i = 2; i <= 7; i++) begin
            exp_beats[n] = f.y[i];
            n++;
        end
        for (int r = 7; r >= 2; r--) begin
            for (int c = 2; c <= 9; c++) begin
                exp_beats[n] = f.z[r][c];
                n++;
            end
        end
        p = 4'd0;
        for (int i = 0; i < 56; i++) p = p ^ exp_beats[i];
        exp_beats[56] = p;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        hdr_we = 0; hdr_t = 0; hdr_x = 0;
        start = 0; out_ready = 1;
        exp_f = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_frame", frame_q, '0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_idx_err", idx_err, 0);
        check("rst_gnts", {a_gnt, b_gnt}, 2'b00);
        rst_n = 1'b1;
        step();

        // Contention: A,B,A,B from PRIO_INIT=0
        drive(1, 2, 4'h5, 1, 7, 2, 4'h3); #1;
        check("c0_gnt", {a_gnt, b_gnt}, 2'b10); step();
        drive(1, 3, 4'h6, 1, 7, 2, 4'h3); #1;
        check("c1_gnt", {a_gnt, b_gnt}, 2'b01); step();
        drive(1, 3, 4'h6, 1, 2, 9, 4'h4); #1;
        check("c2_gnt", {a_gnt, b_gnt}, 2'b10); step();
        drive(1, 4, 4'h7, 1, 2, 9, 4'h4); #1;
        check("c3_gnt", {a_gnt, b_gnt}, 2'b01); step();
        // Lone B: granted, priority stays with A
        drive(0, 4, 4'h7, 1, 3, 5, 4'h9); #1;
        check("lone_b_gnt", {a_gnt, b_gnt}, 2'b01); step();
        drive(1, 4, 4'h7, 1, 3, 5, 4'h9); #1;
        check("c5_gnt", {a_gnt, b_gnt}, 2'b10); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        exp_f.y[2] = 4'h5; exp_f.y[3] = 4'h6; exp_f.y[4] = 4'h7;
        exp_f.z[7][2] = 4'h3; exp_f.z[2][9] = 4'h4; exp_f.z[3][5] = 4'h9;
        #1;
        check("writes_frame", frame_q, exp_f);
        check("no_idx_err", idx_err, 0);
        step();

        // Illegal indices: granted, no write, sticky error
        drive(1, 1, 4'hF, 0, 0, 0, 0); #1;
        check("ill_a_gnt", a_gnt, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ill_a_frame", frame_q, exp_f);
        check("ill_a_err", idx_err, 1);
        drive(0, 0, 0, 1, 3, 4'd10, 4'hF); #1;
        check("ill_b_gnt", b_gnt, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ill_b_frame", frame_q, exp_f);
        step(); step();
        check("err_sticky", idx_err, 1);

        // Header write
        hdr_we = 1; hdr_t = 1; hdr_x = 4'hA;
        step();
        hdr_we = 0;
        exp_f.t = 1'b1; exp_f.x = 4'hA;
        check("hdr_frame", frame_q, exp_f);

        // Full readout with stall at beat 10 and busy lockout at beat 5
        build_beats(exp_f);
        start = 1;
        check("pre_start_busy", busy, 0);
        step();
        start = 0;
        check("valid_after_start", out_valid, 1);
        check("busy_after_start", busy, 1);
        for (int k = 0; k < N_BEATS; k++) begin
            if (k == 4) begin
                start = 1; a_req = 1; a_idx = 5; a_data = 4'h1;
                hdr_we = 1; hdr_t = 0; hdr_x = 4'h3;
                #1;
                check("busy_a_gnt", a_gnt, 0);
            end
            if (k == 5) begin
                start = 0; a_req = 0; hdr_we = 0;
            end
            if (k == 9) begin
                out_ready = 0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check("stall_data", out_data, exp_beats[k]);
                    check("stall_valid", out_valid, 1);
                end
                out_ready = 1;
            end
            check("beat_data", out_data, exp_beats[k]);
            check("beat_last", out_last, (k == N_BEATS - 1));
            step();
        end
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
        check("end_last", out_last, 0);
        check("end_frame", frame_q, exp_f);
        step();
        check("no_restart", busy, 0);

        // Reset in the middle of a readout
        start = 1;
        step();
        start = 0;
        for (int k = 0; k < 19; k++) begin
            check("pre_rst_data", out_data, exp_beats[k]);
            step();
        end
        check("beat20_data", out_data, exp_beats[19]);
        rst_n = 0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        step();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame", frame_q, '0);
        check("rst_mid_err", idx_err, 0);
        rst_n = 1;
        step(); step();
        check("rst_no_beats", out_valid, 0);

        // All-zero frame readout: parity beat, if present, is zero
        exp_f = '0;
        build_beats(exp_f);
        start = 1;
        step();
        start = 0;
        for (int k = 0; k < N_BEATS; k++) begin
            check("zero_data", out_data, exp_beats[k]);
            check("zero_last", out_last, (k == N_BEATS - 1));
            step();
        end
        check("zero_end_busy", busy, 0);

        // Priority returned to A by reset
        drive(1, 2, 4'h1, 1, 2, 2, 4'h1); #1;
        check("prio_after_rst", {a_gnt, b_gnt}, 2'b10);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_write_scheduler.md
FRAME_WRITE_SCHEDULER -- requirements
Module: frame_write_scheduler

Interface
REQ-001 Parameter PRIO_INIT, default 0: requester holding priority after reset (0 = A, 1 = B).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_req  input  1  requester A write request, y-field element.
REQ-005 a_idx  input  3  y element index, legal 2..7.
REQ-006 a_data  input  4  nibble for y[a_idx].
REQ-007 a_gnt  output  1  A write accepted this cycle.
REQ-008 b_req  input  1  requester B write request, z-field element.
REQ-009 b_row  input  3  z row index, legal 2..7.
REQ-010 b_col  input  4  z column index, legal 2..9.
REQ-011 b_data  input  4  nibble for z[b_row][b_col].
REQ-012 b_gnt  output  1  B write accepted this cycle.
REQ-013 hdr_we / hdr_t / hdr_x  input  1/1/4  header write of t and x[5:2]; no arbitration.
REQ-014 start  input  1  begin readout of frame.
REQ-015 busy  output  1  readout in progress.
REQ-016 out_valid / out_ready / out_data / out_last  output/input/output/output  1/1/4/1  nibble stream.
REQ-017 idx_err  output  1  sticky: a granted write carried an illegal index.
REQ-018 frame_q  output  221  frame register {t, x, y[2:7], z[7:2][2:9]}, MSB first.

Function
REQ-019 Frame fields SHALL be written only via grants or hdr_we; one y or z write per cycle.
REQ-020 a_gnt/b_gnt SHALL be combinational from req and priority, low whenever busy.
REQ-021 Both requesting: grant the priority holder; priority SHALL toggle to the other requester after every grant to the holder; lone requester always granted, priority unchanged.
REQ-022 Granted write SHALL appear in frame_q the following cycle.
REQ-023 Granted write with illegal index SHALL leave frame_q unchanged and set idx_err until reset.
REQ-024 hdr_we SHALL update t and x the following cycle, any time except while busy (ignored then).
REQ-025 FSM states IDLE, HDR, YSEQ, ZSEQ; start in IDLE -> HDR, start while busy ignored.
REQ-026 Beat order: {3'b000,t}, x; y[2]..y[7]; z rows 7 down to 2, columns 2..9 within row; 56 beats total.
REQ-027 Beat transfers when out_valid && out_ready; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-028 out_valid SHALL assert the cycle after start is accepted and stay high until the last beat transfers.
REQ-029 out_last SHALL be high only on the final beat; after it transfers -> IDLE, busy low next cycle.
REQ-030 Readout SHALL sample frame_q live; writes cannot occur while busy so stream is consistent.

Reset
REQ-031 rst_n low: frame_q=0, state IDLE, busy=0, out_valid=0, out_last=0, out_data=0, idx_err=0, priority=PRIO_INIT, gnts low.
REQ-032 Reset mid-readout SHALL abort immediately; no further beats.

Configuration
REQ-033 Macro FRAME_PARITY_EN defined: one extra beat after z[2][9] carrying XOR of all 56 prior nibbles; out_last moves to it (57 beats).
REQ-034 Macro undefined: 56 beats, no parity logic.

Structure
REQ-035 Package frame_pkg SHALL hold packed typedefs sy_t (y[2:7][3:0]), frame_t, state enum, constants Y_BEATS=6, Z_BEATS=48, HDR_BEATS=2.
REQ-036 Sub-module rr_arb2 SHALL implement the two-way round-robin arbiter.

Verification
REQ-037 Both req every cycle from reset, PRIO_INIT=0 -> grants A,B,A,B; all four writes land in frame_q.
REQ-038 a_req, a_idx=1 -> a_gnt=1, frame_q unchanged, idx_err=1 and stays 1.
REQ-039 hdr t=1 x=4'hA, y[2]=4'h5, z[7][2]=4'h3, start, out_ready=1 -> beats 1,A,5,... beat 9 = 3, out_last on beat 56.
REQ-040 out_ready low for 3 cycles at beat 10 -> out_data constant, no beat lost or repeated.
REQ-041 start and a_req during busy -> a_gnt=0, start ignored, stream unaffected.
REQ-042 rst_n low at beat 20 -> out_valid=0, busy=0 next edge, frame_q=0; FRAME_PARITY_EN build: all-zero frame -> 57th beat 0 with out_last.
